// File: rtl/cpu_pkg.sv
// Shared datapath types and constants for the 16-bit CPU front end.
package cpu_pkg;
  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_st_e;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: instruction-memory handshake, decode handshake and redirect inputs.
interface fetch_pc_unit_if;
  import cpu_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ready;
  word_t imem_data;
  logic  instr_valid;
  word_t instr;
  word_t pc_out;
  logic  stall;
  logic  branch_taken;
  word_t branch_offset;
  logic  flush;
  word_t flush_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc_out,
    input  imem_ready, imem_data, stall, branch_taken, branch_offset, flush, flush_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc_out,
    output imem_ready, imem_data, stall, branch_taken, branch_offset, flush, flush_pc
  );
endinterface

// File: rtl/pc_target_adder.sv
// Wrapping PC adder; shared by sequential fetch, branches and later jump logic.
module pc_target_adder
  import cpu_pkg::*;
(
  input  word_t base,
  input  word_t inc,
  output word_t target
);
  assign target = base + inc;
endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per request, redirects on branch/flush.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  fetch_pc_unit_if.master bus
);
  fetch_st_e state, state_n;
  word_t     fetch_pc, fetch_pc_n;
  word_t     flush_tgt, flush_tgt_n;
  word_t     instr_q, pc_q;
  logic      req_q, vld_q;
  logic      capture;
  word_t     inc, target;

  assign inc = bus.branch_taken ? bus.branch_offset : word_t'(1);

  pc_target_adder u_adder (
    .base   (pc_q),
    .inc    (inc),
    .target (target)
  );

  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    flush_tgt_n = flush_tgt;
    capture     = 1'b0;
    unique case (state)
      FETCH: begin
        // req_q is low only in the first cycle out of reset: nothing is outstanding yet
        if (!req_q) begin
          if (bus.flush) fetch_pc_n = bus.flush_pc;
        end else if (bus.imem_ready) begin
          if (bus.flush) begin
            fetch_pc_n = bus.flush_pc;
          end else begin
            capture = 1'b1;
            state_n = HOLD;
          end
        end else if (bus.flush) begin
          flush_tgt_n = bus.flush_pc;
          state_n     = DRAIN;
        end
      end
      HOLD: begin
        if (bus.flush) begin
          fetch_pc_n = bus.flush_pc;
          state_n    = FETCH;
        end else if (!bus.stall) begin
          fetch_pc_n = target;
          state_n    = FETCH;
        end
      end
      DRAIN: begin
        // request cannot be withdrawn; returned word is dropped
        if (bus.imem_ready) begin
          fetch_pc_n = bus.flush ? bus.flush_pc : flush_tgt;
          state_n    = FETCH;
        end else if (bus.flush) begin
          flush_tgt_n = bus.flush_pc;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      flush_tgt <= RESET_PC;
      instr_q   <= '0;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      flush_tgt <= flush_tgt_n;
      req_q     <= (state_n != HOLD);
      vld_q     <= (state_n == HOLD);
      if (capture) begin
        instr_q <= bus.imem_data;
        pc_q    <= fetch_pc;
      end
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = vld_q;
  assign bus.instr       = instr_q;
  assign bus.pc_out      = pc_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed plan plus randomized traffic for fetch_pc_unit against a flag-based behavioural model.
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(.RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // instruction memory: word at address a holds a + 16'hA001
  assign bus.imem_data = bus.imem_addr + 16'hA001;

  // reference model state
  logic        m_req, m_valid, m_drain;
  logic [15:0] m_addr, m_instr, m_pc, m_tgt;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_valid = 0; m_drain = 0;
    m_addr = 16'h0000; m_instr = 16'h0000; m_pc = 16'h0000; m_tgt = 16'h0000;
  endtask

  // next-cycle behaviour from the current inputs
  task automatic model_step();
    int sum;
    if (m_valid) begin
      if (bus.flush) begin
        m_valid = 0; m_req = 1; m_addr = bus.flush_pc;
      end else if (!bus.stall) begin
        sum = bus.branch_taken ? int'(m_pc) + int'(bus.branch_offset) : int'(m_pc) + 1;
        m_valid = 0; m_req = 1; m_addr = 16'(sum % 65536);
      end
    end else if (!m_req) begin
      m_req = 1;
      if (bus.flush) m_addr = bus.flush_pc;
    end else if (bus.imem_ready) begin
      if (bus.flush || m_drain) begin
        m_addr = bus.flush ? bus.flush_pc : m_tgt;
        m_drain = 0;
      end else begin
        m_valid = 1; m_req = 0; m_instr = m_addr + 16'hA001; m_pc = m_addr;
      end
    end else if (bus.flush) begin
      m_drain = 1; m_tgt = bus.flush_pc;
    end
  endtask

  task automatic check_outputs();
    chk("req",   16'(bus.imem_req), 16'(m_req));
    chk("addr",  bus.imem_addr, m_addr);
    chk("valid", 16'(bus.instr_valid), 16'(m_valid));
    chk("instr", bus.instr, m_instr);
    chk("pc",    bus.pc_out, m_pc);
    chk("req_valid_excl", 16'(bus.imem_req & bus.instr_valid), 16'h0000);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},   16'(bus.imem_req), 16'h0000);
    chk({tag, "_addr"},  bus.imem_addr, 16'h0000);
    chk({tag, "_valid"}, 16'(bus.instr_valid), 16'h0000);
    chk({tag, "_instr"}, bus.instr, 16'h0000);
    chk({tag, "_pc"},    bus.pc_out, 16'h0000);
  endtask

  task automatic step(input logic rdy, input logic stl, input logic br,
                      input logic [15:0] off, input logic fl, input logic [15:0] fpc);
    bus.imem_ready = rdy; bus.stall = stl; bus.branch_taken = br;
    bus.branch_offset = off; bus.flush = fl; bus.flush_pc = fpc;
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // asynchronous reset mid-cycle, checked before any clock edge
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.imem_ready = 0; bus.stall = 0; bus.branch_taken = 0;
    bus.branch_offset = 0; bus.flush = 0; bus.flush_pc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;

    // zero-wait fetch of two sequential words
    step(0, 0, 0, 16'h0000, 0, 16'h0000);
    chk("tp1_req0", 16'(bus.imem_req), 16'h0001);
    chk("tp1_addr0", bus.imem_addr, 16'h0000);
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    chk("tp1_instr0", bus.instr, 16'hA001);
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    chk("tp1_addr1", bus.imem_addr, 16'h0001);
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    chk("tp1_instr1", bus.instr, 16'hA002);
    chk("tp1_pc1", bus.pc_out, 16'h0001);

    // branch with negative and positive offsets from 0x0002
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    chk("br_pc", bus.pc_out, 16'h0002);
    step(1, 0, 1, 16'hFFF2, 0, 16'h0000);
    chk("br_neg", bus.imem_addr, 16'hFFF4);
    step(1, 0, 0, 16'h0000, 1, 16'h0002);
    chk("flush_rdy", bus.imem_addr, 16'h0002);
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    step(1, 0, 1, 16'h0010, 0, 16'h0000);
    chk("br_pos", bus.imem_addr, 16'h0012);

    // stall holds instruction and ignores branch
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 16'h0055, 0, 16'h0000);
      chk("stall_pc", bus.pc_out, 16'h0012);
      chk("stall_req", 16'(bus.imem_req), 16'h0000);
    end
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    chk("unstall_addr", bus.imem_addr, 16'h0013);

    // flush during a slow fetch drains the old request
    step(0, 0, 0, 16'h0000, 1, 16'h0100);
    step(0, 0, 0, 16'h0000, 0, 16'h0000);
    step(0, 0, 0, 16'h0000, 0, 16'h0000);
    chk("drain_addr", bus.imem_addr, 16'h0013);
    chk("drain_req", 16'(bus.imem_req), 16'h0001);
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    chk("drain_valid", 16'(bus.instr_valid), 16'h0000);
    chk("drain_target", bus.imem_addr, 16'h0100);

    // PC wrap from 0xFFFF
    step(1, 0, 0, 16'h0000, 1, 16'hFFFF);
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    chk("wrap_pc", bus.pc_out, 16'hFFFF);
    step(1, 0, 0, 16'h0000, 0, 16'h0000);
    chk("wrap_addr", bus.imem_addr, 16'h0000);

    // reset asserted while a request is outstanding
    do_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        step(($urandom % 3) != 0, ($urandom % 4) == 0, $urandom % 2,
             16'($urandom), ($urandom % 16) == 0, 16'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
